// File: rtl/sync_gen_pkg.sv
// Shared constants and types for the per-virtual-channel CSI-2 sync generator.
package sync_gen_pkg;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    LINE  = 2'd2
  } sync_state_e;

  localparam int unsigned ERR_W            = 4;
  localparam int unsigned ERR_FE_NO_FRAME  = 0;
  localparam int unsigned ERR_FS_IN_FRAME  = 1;
  localparam int unsigned ERR_PAY_NO_FRAME = 2;
  localparam int unsigned ERR_FE_IN_LINE   = 3;

endpackage

// File: rtl/sync_gen_ch.sv
// Single virtual channel: frame/line FSM, line and pixel counters, error pulses.
module sync_gen_ch
  import sync_gen_pkg::*;
#(
  parameter int unsigned LINE_CNT_W  = 12,
  parameter int unsigned PIX_CNT_W   = 13,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter bit          HSYNC_POL   = 1'b1,
  parameter bit          TOGGLE_MODE = 1'b0
) (
  input  logic                  pixel_clk_i,
  input  logic                  pixel_rst_i,
  input  logic                  fs,
  input  logic                  fe,
  input  logic                  pay,
  output logic                  vsync,
  output logic                  hsync,
  output logic [LINE_CNT_W-1:0] lines,
  output logic [PIX_CNT_W-1:0]  line_len,
  output logic                  frame_done,
  output logic [ERR_W-1:0]      err
);

  localparam logic V_ON  = VSYNC_POL;
  localparam logic V_OFF = ~VSYNC_POL;
  localparam logic H_ON  = HSYNC_POL;
  localparam logic H_OFF = ~HSYNC_POL;
  localparam logic [PIX_CNT_W-1:0]  PIX_ONE  = PIX_CNT_W'(1);
  localparam logic [LINE_CNT_W-1:0] LINE_ONE = LINE_CNT_W'(1);

  sync_state_e           state;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [PIX_CNT_W-1:0]  pix_cnt;
  logic [LINE_CNT_W-1:0] line_inc;
  logic [PIX_CNT_W-1:0]  pix_inc;

  // Saturating increments
  assign line_inc = (line_cnt == '1) ? line_cnt : line_cnt + LINE_ONE;
  assign pix_inc  = (pix_cnt == '1) ? pix_cnt : pix_cnt + PIX_ONE;

  always_ff @(posedge pixel_clk_i or posedge pixel_rst_i) begin
    if (pixel_rst_i) begin
      state      <= IDLE;
      line_cnt   <= '0;
      pix_cnt    <= '0;
      lines      <= '0;
      line_len   <= '0;
      vsync      <= V_OFF;
      hsync      <= H_OFF;
      frame_done <= 1'b0;
      err        <= '0;
    end else begin
      frame_done <= 1'b0;
      err        <= '0;
      case (state)
        IDLE: begin
          if (fs) begin
            line_cnt <= '0;
            vsync    <= V_ON;
            if (pay) begin
              state   <= LINE;
              pix_cnt <= PIX_ONE;
              hsync   <= H_ON;
            end else begin
              state <= FRAME;
            end
          end else if (fe) begin
            err[ERR_FE_NO_FRAME] <= 1'b1;
          end else if (pay) begin
            err[ERR_PAY_NO_FRAME] <= 1'b1;
          end
        end
        FRAME: begin
          if (fs) begin
            err[ERR_FS_IN_FRAME] <= 1'b1;
            line_cnt             <= '0;
            if (pay) begin
              state   <= LINE;
              pix_cnt <= PIX_ONE;
              hsync   <= H_ON;
            end
          end else if (fe) begin
            state      <= IDLE;
            lines      <= line_cnt;
            frame_done <= 1'b1;
            vsync      <= V_OFF;
          end else if (pay) begin
            state   <= LINE;
            pix_cnt <= PIX_ONE;
            hsync   <= H_ON;
          end
        end
        LINE: begin
          if (fs) begin
            // Restart: the open line is dropped without being counted
            err[ERR_FS_IN_FRAME] <= 1'b1;
            line_cnt             <= '0;
            state                <= FRAME;
            hsync                <= H_OFF;
          end else if (fe) begin
            err[ERR_FE_IN_LINE] <= 1'b1;
            line_len            <= pay ? pix_inc : pix_cnt;
            lines               <= line_inc;
            frame_done          <= 1'b1;
            state               <= IDLE;
            vsync               <= V_OFF;
            hsync               <= H_OFF;
          end else if (pay) begin
            pix_cnt <= pix_inc;
          end else begin
            line_len <= pix_cnt;
            line_cnt <= line_inc;
            state    <= FRAME;
            hsync    <= H_OFF;
          end
        end
        default: state <= IDLE;
      endcase
      // Legacy toggle mode overrides the level-mode vsync written above
      if (TOGGLE_MODE) vsync <= fs ? ~vsync : vsync;
    end
  end

endmodule

// File: rtl/sync_gen_vc.sv
// Per-VC frame/line sync generator: decodes FS/FE and payload into NUM_VC channels.
module sync_gen_vc
  import sync_gen_pkg::*;
#(
  parameter int unsigned NUM_VC      = 1,
  parameter int unsigned LINE_CNT_W  = 12,
  parameter int unsigned PIX_CNT_W   = 13,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter bit          HSYNC_POL   = 1'b1,
  parameter bit          TOGGLE_MODE = 1'b0
) (
  input  logic                         pixel_clk_i,
  input  logic                         pixel_rst_i,
  input  logic                         sp_en_i,
  input  logic [5:0]                   sp_dt_i,
  input  logic [1:0]                   sp_vc_i,
  input  logic                         lp_en_i,
  input  logic [1:0]                   lp_vc_i,
  output logic [NUM_VC-1:0]            vsync_o,
  output logic [NUM_VC-1:0]            hsync_o,
  output logic [NUM_VC*LINE_CNT_W-1:0] lines_o,
  output logic [NUM_VC*PIX_CNT_W-1:0]  line_len_o,
  output logic [NUM_VC-1:0]            frame_done_o,
  output logic [ERR_W-1:0]             err_o
);

  logic [ERR_W-1:0] err_ch [NUM_VC];

  for (genvar i = 0; i < NUM_VC; i++) begin : g_ch
    logic fs_c;
    logic fe_c;
    logic pay_c;

    // VCs at or above NUM_VC never match a channel and are dropped here
    assign fs_c  = sp_en_i && (sp_dt_i == DT_FS) && (sp_vc_i == 2'(i));
    assign fe_c  = sp_en_i && (sp_dt_i == DT_FE) && (sp_vc_i == 2'(i));
    assign pay_c = lp_en_i && (lp_vc_i == 2'(i));

    sync_gen_ch #(
      .LINE_CNT_W  (LINE_CNT_W),
      .PIX_CNT_W   (PIX_CNT_W),
      .VSYNC_POL   (VSYNC_POL),
      .HSYNC_POL   (HSYNC_POL),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_ch (
      .pixel_clk_i (pixel_clk_i),
      .pixel_rst_i (pixel_rst_i),
      .fs          (fs_c),
      .fe          (fe_c),
      .pay         (pay_c),
      .vsync       (vsync_o[i]),
      .hsync       (hsync_o[i]),
      .lines       (lines_o[i*LINE_CNT_W +: LINE_CNT_W]),
      .line_len    (line_len_o[i*PIX_CNT_W +: PIX_CNT_W]),
      .frame_done  (frame_done_o[i]),
      .err         (err_ch[i])
    );
  end

  // Error pulses are registered per channel; merge across VCs
  always_comb begin
    err_o = '0;
    for (int i = 0; i < NUM_VC; i++) err_o = err_o | err_ch[i];
  end

endmodule

// File: tb/tb_sync_gen_vc.sv
// Bench: two-VC level-mode instance and one-VC toggle-mode instance against a frame/line model.
module tb_sync_gen_vc;

  localparam int PMAX = 8191;
  localparam int LMAX = 4095;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp_en;
  logic [5:0]  sp_dt;
  logic [1:0]  sp_vc;
  logic        lp_en;
  logic [1:0]  lp_vc;

  logic [1:0]  vs, hs, done;
  logic [23:0] lines;
  logic [25:0] len;
  logic [3:0]  err;

  logic [0:0]  t_vs, t_hs, t_done;
  logic [11:0] t_lines;
  logic [12:0] t_len;
  logic [3:0]  t_err;

  sync_gen_vc #(.NUM_VC(2)) dut (
    .pixel_clk_i(clk), .pixel_rst_i(rst),
    .sp_en_i(sp_en), .sp_dt_i(sp_dt), .sp_vc_i(sp_vc),
    .lp_en_i(lp_en), .lp_vc_i(lp_vc),
    .vsync_o(vs), .hsync_o(hs), .lines_o(lines), .line_len_o(len),
    .frame_done_o(done), .err_o(err)
  );

  sync_gen_vc #(.NUM_VC(1), .VSYNC_POL(1'b0), .TOGGLE_MODE(1'b1)) dut_t (
    .pixel_clk_i(clk), .pixel_rst_i(rst),
    .sp_en_i(sp_en), .sp_dt_i(sp_dt), .sp_vc_i(sp_vc),
    .lp_en_i(lp_en), .lp_vc_i(lp_vc),
    .vsync_o(t_vs), .hsync_o(t_hs), .lines_o(t_lines), .line_len_o(t_len),
    .frame_done_o(t_done), .err_o(t_err)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: frame/line membership and counts per VC
  int         m_frame [2];
  int         m_line  [2];
  int         m_pix   [2];
  int         m_lcnt  [2];
  int         m_lines [2];
  int         m_len   [2];
  logic       m_done  [2];
  logic [3:0] m_err   [2];
  logic       m_tv;

  logic [3:0] err_acc;
  logic       hs0_seen;
  int         done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < 2; v++) begin
      m_frame[v] = 0; m_line[v] = 0; m_pix[v] = 0; m_lcnt[v] = 0;
      m_lines[v] = 0; m_len[v] = 0; m_done[v] = 1'b0; m_err[v] = 4'h0;
    end
    m_tv = 1'b1;
  endtask

  task automatic model_step(input logic se, input logic [5:0] dt, input logic [1:0] sv,
                            input logic le, input logic [1:0] lv);
    for (int v = 0; v < 2; v++) begin
      bit fs, fe, pay;
      fs  = se && (dt == 6'h00) && (sv == 2'(v));
      fe  = se && (dt == 6'h01) && (sv == 2'(v));
      pay = le && (lv == 2'(v));
      m_done[v] = 1'b0;
      m_err[v]  = 4'h0;
      if (m_frame[v] == 0) begin
        if (fs) begin
          m_frame[v] = 1; m_lcnt[v] = 0;
          if (pay) begin m_line[v] = 1; m_pix[v] = 1; end
        end else if (fe) m_err[v][0] = 1'b1;
        else if (pay) m_err[v][2] = 1'b1;
      end else if (m_line[v] == 0) begin
        if (fs) begin
          m_err[v][1] = 1'b1; m_lcnt[v] = 0;
          if (pay) begin m_line[v] = 1; m_pix[v] = 1; end
        end else if (fe) begin
          m_frame[v] = 0; m_lines[v] = m_lcnt[v]; m_done[v] = 1'b1;
        end else if (pay) begin
          m_line[v] = 1; m_pix[v] = 1;
        end
      end else begin
        if (fs) begin
          m_err[v][1] = 1'b1; m_lcnt[v] = 0; m_line[v] = 0;
        end else if (fe) begin
          if (pay) m_pix[v] = (m_pix[v] < PMAX) ? m_pix[v] + 1 : PMAX;
          m_len[v]   = m_pix[v];
          m_lcnt[v]  = (m_lcnt[v] < LMAX) ? m_lcnt[v] + 1 : LMAX;
          m_lines[v] = m_lcnt[v];
          m_done[v]  = 1'b1;
          m_err[v][3] = 1'b1;
          m_frame[v] = 0; m_line[v] = 0;
        end else if (pay) begin
          m_pix[v] = (m_pix[v] < PMAX) ? m_pix[v] + 1 : PMAX;
        end else begin
          m_len[v]  = m_pix[v];
          m_lcnt[v] = (m_lcnt[v] < LMAX) ? m_lcnt[v] + 1 : LMAX;
          m_line[v] = 0;
        end
      end
      if (v == 0 && fs) m_tv = ~m_tv;
    end
  endtask

  task automatic check_all();
    for (int v = 0; v < 2; v++) begin
      chk("vsync", 32'(vs[v]), 32'(m_frame[v]));
      chk("hsync", 32'(hs[v]), 32'(m_line[v]));
      chk("lines", 32'(lines[v*12 +: 12]), 32'(m_lines[v]));
      chk("line_len", 32'(len[v*13 +: 13]), 32'(m_len[v]));
      chk("frame_done", 32'(done[v]), 32'(m_done[v]));
    end
    chk("err", 32'(err), 32'(m_err[0] | m_err[1]));
    chk("t_vsync", 32'(t_vs), 32'(m_tv));
    chk("t_hsync", 32'(t_hs), 32'(m_line[0]));
    chk("t_lines", 32'(t_lines), 32'(m_lines[0]));
    chk("t_line_len", 32'(t_len), 32'(m_len[0]));
    chk("t_frame_done", 32'(t_done), 32'(m_done[0]));
    chk("t_err", 32'(t_err), 32'(m_err[0]));
  endtask

  task automatic tick(input logic se, input logic [5:0] dt, input logic [1:0] sv,
                      input logic le, input logic [1:0] lv);
    sp_en = se; sp_dt = dt; sp_vc = sv; lp_en = le; lp_vc = lv;
    @(posedge clk);
    model_step(se, dt, sv, le, lv);
    #1;
    check_all();
    err_acc  = err_acc | err;
    hs0_seen = hs0_seen | hs[0];
    done_cnt += int'(done[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 6'h00, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic send_fs(input logic [1:0] vc);
    tick(1'b1, 6'h00, vc, 1'b0, 2'd0);
  endtask

  task automatic send_fe(input logic [1:0] vc);
    tick(1'b1, 6'h01, vc, 1'b0, 2'd0);
  endtask

  task automatic pay(input int n, input logic [1:0] vc);
    for (int i = 0; i < n; i++) tick(1'b0, 6'h00, 2'd0, 1'b1, vc);
  endtask

  task automatic clear_acc();
    err_acc = 4'h0; hs0_seen = 1'b0; done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sp_en = 1'b0; sp_dt = 6'h00; sp_vc = 2'd0; lp_en = 1'b0; lp_vc = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic se, le, lp_on;
    logic [5:0] dt;
    logic [1:0] sv, lv;

    model_clear();
    clear_acc();
    do_reset();
    idle(2);

    // Toggle-mode instance: vsync (active low) flips on each FS only
    chk("tog_reset", 32'(t_vs), 32'd1);
    send_fs(2'd0);
    chk("tog_fs1", 32'(t_vs), 32'd0);
    send_fe(2'd0);
    chk("tog_fe1", 32'(t_vs), 32'd0);
    send_fs(2'd0);
    chk("tog_fs2", 32'(t_vs), 32'd1);
    send_fe(2'd0);
    chk("tog_fe2", 32'(t_vs), 32'd1);

    // Three 640-pixel lines on VC0
    clear_acc();
    send_fs(2'd0);
    for (int l = 0; l < 3; l++) begin
      pay(640, 2'd0);
      idle(10);
    end
    send_fe(2'd0);
    chk("t1_lines", 32'(lines[11:0]), 32'd3);
    chk("t1_len", 32'(len[12:0]), 32'd640);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_err", 32'(err_acc), 32'd0);
    idle(2);

    // FE without FS
    clear_acc();
    send_fe(2'd0);
    chk("t2_err", 32'(err), 32'h1);
    chk("t2_vsync", 32'(vs[0]), 32'd0);
    chk("t2_lines", 32'(lines[11:0]), 32'd3);
    idle(2);

    // Frame restart
    clear_acc();
    send_fs(2'd0);
    pay(20, 2'd0); idle(3);
    pay(20, 2'd0); idle(3);
    send_fs(2'd0);
    pay(15, 2'd0); idle(3);
    send_fe(2'd0);
    chk("t3_err1", 32'(err_acc), 32'h2);
    chk("t3_lines", 32'(lines[11:0]), 32'd1);
    idle(2);

    // FE arriving with the last pixel of a 100-pixel line
    send_fs(2'd0);
    pay(99, 2'd0);
    chk("t4_hsync_open", 32'(hs[0]), 32'd1);
    tick(1'b1, 6'h01, 2'd0, 1'b1, 2'd0);
    chk("t4_err", 32'(err), 32'h8);
    chk("t4_len", 32'(len[12:0]), 32'd100);
    chk("t4_lines", 32'(lines[11:0]), 32'd1);
    chk("t4_vh", 32'({vs[0], hs[0]}), 32'd0);
    idle(2);

    // Two VCs interleaved, payload on VC1 only, stray payload on VC3
    clear_acc();
    send_fs(2'd0);
    send_fs(2'd1);
    pay(50, 2'd1); idle(4);
    pay(10, 2'd3);
    pay(50, 2'd1); idle(4);
    send_fe(2'd0);
    send_fe(2'd1);
    chk("t5_hs0", 32'(hs0_seen), 32'd0);
    chk("t5_err", 32'(err_acc), 32'd0);
    chk("t5_lines1", 32'(lines[23:12]), 32'd2);
    chk("t5_len1", 32'(len[25:13]), 32'd50);
    idle(2);

    // Pixel counter saturation
    send_fs(2'd0);
    pay(8200, 2'd0);
    idle(1);
    chk("t6_len_sat", 32'(len[12:0]), 32'd8191);
    send_fe(2'd0);
    idle(2);

    // Randomized traffic, all VCs, FS/FE/LS/LE
    lp_on = 1'b0;
    lv = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      se = ($urandom_range(0, 15) == 0);
      dt = 6'($urandom_range(0, 3));
      sv = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        lp_on = ~lp_on;
        if (lp_on) lv = 2'($urandom_range(0, 3));
      end
      le = lp_on;
      tick(se, dt, sv, le, lv);
    end
    idle(2);

    // Async reset mid-line: outputs go inactive without a clock edge
    do_reset();
    idle(1);
    send_fs(2'd0);
    pay(5, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_vs", 32'(vs), 32'd0);
    chk("rst_hs", 32'(hs), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_t_vs", 32'(t_vs), 32'd1);
    chk("rst_t_hs", 32'(t_hs), 32'd0);
    chk("rst_lines", 32'(lines), 32'd0);
    do_reset();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
